// File: rtl/pwm_regs_if.sv
// Byte bus between the SPI slave (master modport) and pwm_regs (slave modport).
// Signal names follow the register block's port view: _i flows into pwm_regs, _o flows out.
interface pwm_regs_if;
    logic [7:0] b_addr_i;
    logic [7:0] b_data_i;
    logic       b_write_i;
    logic [7:0] b_data_o;

    modport master (
        output b_addr_i,
        output b_data_i,
        output b_write_i,
        input  b_data_o
    );

    modport slave (
        input  b_addr_i,
        input  b_data_i,
        input  b_write_i,
        output b_data_o
    );
endinterface

// File: rtl/pwm_regs.sv
// PWM register map fed by the SPI slave byte bus, driving CHANNELS prescaled PWM outputs.
// Define PWM_SHADOW_EN to double-buffer PERIOD/DUTY so updates land only on period wrap.
module pwm_regs #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    pwm_regs_if.slave           bus,
    output logic [CHANNELS-1:0] pwm_o,
    output logic                period_o
);
    logic             wr_meta_q, wr_sync_q, wr_prev_q, wr_evt;
    logic             en_q, inv_q, status_q;
    logic [CNT_W-1:0] prescale_q, period_q, pcnt_q, cnt_q;
    logic [CNT_W-1:0] duty_q    [CHANNELS];
    logic [CNT_W-1:0] duty_rd   [CHANNELS];
    logic [CNT_W-1:0] duty_wr   [CHANNELS];
    logic [CNT_W-1:0] period_rd, period_wr;
    logic             sel_ctrl, sel_pre, sel_per, sel_status;
    logic [CHANNELS-1:0] sel_duty;
    logic             tick, wrap;
    logic [7:0]       rdata;

    // b_addr_i/b_data_i are held stable while the strobe is high, so only the strobe is synced.
    assign wr_evt = wr_sync_q & ~wr_prev_q;

    always_comb begin
        sel_ctrl   = (bus.b_addr_i == 8'h00);
        sel_pre    = (bus.b_addr_i == 8'h01);
        sel_per    = (bus.b_addr_i == 8'h02);
        sel_status = (bus.b_addr_i == 8'h03);
        for (int n = 0; n < int'(CHANNELS); n++) begin
            sel_duty[n] = (bus.b_addr_i == 8'h10 + 8'(n));
        end
    end

`ifdef PWM_SHADOW_EN
    logic [CNT_W-1:0] period_sh_q;
    logic [CNT_W-1:0] duty_sh_q [CHANNELS];
    logic             load;

    assign load      = wrap | ~en_q;
    assign period_rd = period_sh_q;
    always_comb begin
        for (int n = 0; n < int'(CHANNELS); n++) duty_rd[n] = duty_sh_q[n];
    end
`else
    assign period_rd = period_q;
    always_comb begin
        for (int n = 0; n < int'(CHANNELS); n++) duty_rd[n] = duty_q[n];
    end
`endif

    // Next value of the software-visible copy (shadow when buffered, active otherwise).
    always_comb begin
        period_wr = (wr_evt && sel_per) ? bus.b_data_i : period_rd;
        for (int n = 0; n < int'(CHANNELS); n++) begin
            duty_wr[n] = (wr_evt && sel_duty[n]) ? bus.b_data_i : duty_rd[n];
        end
    end

    // Compare with >= so a PERIOD shrunk below cnt wraps immediately instead of running out.
    assign tick = en_q && (pcnt_q >= prescale_q);
    assign wrap = tick && (cnt_q >= period_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_meta_q  <= 1'b0;
            wr_sync_q  <= 1'b0;
            wr_prev_q  <= 1'b0;
            en_q       <= 1'b0;
            inv_q      <= 1'b0;
            status_q   <= 1'b0;
            prescale_q <= '0;
            period_q   <= '0;
            pcnt_q     <= '0;
            cnt_q      <= '0;
            period_o   <= 1'b0;
            pwm_o      <= '0;
            for (int n = 0; n < int'(CHANNELS); n++) duty_q[n] <= '0;
`ifdef PWM_SHADOW_EN
            period_sh_q <= '0;
            for (int n = 0; n < int'(CHANNELS); n++) duty_sh_q[n] <= '0;
`endif
        end else begin
            wr_meta_q <= bus.b_write_i;
            wr_sync_q <= wr_meta_q;
            wr_prev_q <= wr_sync_q;

            if (wr_evt && sel_ctrl) begin
                en_q  <= bus.b_data_i[0];
                inv_q <= bus.b_data_i[1];
            end
            if (wr_evt && sel_pre) prescale_q <= bus.b_data_i;

`ifdef PWM_SHADOW_EN
            period_sh_q <= period_wr;
            if (load) period_q <= period_wr;
            for (int n = 0; n < int'(CHANNELS); n++) begin
                duty_sh_q[n] <= duty_wr[n];
                if (load) duty_q[n] <= duty_wr[n];
            end
`else
            period_q <= period_wr;
            for (int n = 0; n < int'(CHANNELS); n++) duty_q[n] <= duty_wr[n];
`endif

            // Set wins over a same-cycle clear.
            if (wrap) begin
                status_q <= 1'b1;
            end else if (wr_evt && sel_status) begin
                status_q <= 1'b0;
            end

            if (!en_q) begin
                pcnt_q <= '0;
                cnt_q  <= '0;
            end else begin
                pcnt_q <= tick ? '0 : pcnt_q + 1'b1;
                if (tick) cnt_q <= wrap ? '0 : cnt_q + 1'b1;
            end

            period_o <= wrap;
            for (int n = 0; n < int'(CHANNELS); n++) begin
                pwm_o[n] <= en_q ? ((cnt_q < duty_q[n]) ^ inv_q) : inv_q;
            end
        end
    end

    always_comb begin
        rdata = 8'h00;
        if (sel_ctrl) begin
            rdata = {6'b0, inv_q, en_q};
        end else if (sel_pre) begin
            rdata = prescale_q;
        end else if (sel_per) begin
            rdata = period_rd;
        end else if (sel_status) begin
            rdata = {7'b0, status_q};
        end else begin
            for (int n = 0; n < int'(CHANNELS); n++) begin
                if (sel_duty[n]) rdata = duty_rd[n];
            end
        end
    end

    assign bus.b_data_o = rdata;
endmodule

// File: tb/tb_pwm_regs.sv
// Randomized bench for pwm_regs: register writes over the byte bus, period/duty measured
// against closed-form expectations ((PERIOD+1)*(PRESCALE+1) cycles, DUTY*(PRESCALE+1) high).
module tb_pwm_regs;
    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] pwm;
    logic          period;

    pwm_regs_if bus ();

    pwm_regs #(.CHANNELS(CH), .CNT_W(8)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .bus     (bus),
        .pwm_o   (pwm),
        .period_o(period)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference register state
    bit m_en, m_inv;
    int m_pre, m_per;
    int m_duty [CH];

    int m_len;
    int hi [CH];
    bit meas_ok;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_en = 0; m_inv = 0; m_pre = 0; m_per = 0;
        foreach (m_duty[i]) m_duty[i] = 0;
    endfunction

    function automatic void model_write(input int a, input int d);
        if (a == 0) begin
            m_en = d[0]; m_inv = d[1];
        end else if (a == 1) m_pre = d;
        else if (a == 2) m_per = d;
        else if (a >= 16 && a < 16 + CH) m_duty[a-16] = d;
    endfunction

    function automatic int exp_read(input int a);
        if (a == 0) return (int'(m_inv) << 1) | int'(m_en);
        if (a == 1) return m_pre;
        if (a == 2) return m_per;
        if (a >= 16 && a < 16 + CH) return m_duty[a-16];
        return 0;
    endfunction

    task automatic strobe_on(input logic [7:0] a, input logic [7:0] d);
        bus.b_addr_i  = a;
        bus.b_data_i  = d;
        bus.b_write_i = 1'b1;
    endtask

    task automatic bus_write(input int a, input int d);
        @(negedge clk);
        strobe_on(8'(a), 8'(d));
        repeat (4) @(negedge clk);
        bus.b_write_i = 1'b0;
        repeat (3) @(negedge clk);
        model_write(a, d);
    endtask

    task automatic rd(input int a, output int v);
        bus.b_addr_i = 8'(a);
        #1;
        v = int'(bus.b_data_o);
    endtask

    task automatic read_check(input string tag, input int a);
        int v;
        rd(a, v);
        check(tag, v, exp_read(a));
    endtask

    // Waits for one period_o, then counts cycles and pwm highs up to the next one.
    task automatic measure();
        bit seen = 0;
        meas_ok = 0;
        m_len   = 0;
        foreach (hi[i]) hi[i] = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (period) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            check("wait_period", 0, 1);
            return;
        end
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < CH; c++) hi[c] += int'(pwm[c]);
            m_len++;
            @(negedge clk);
            if (period) begin
                meas_ok = 1;
                break;
            end
        end
        if (!meas_ok) check("period_timeout", 0, 1);
    endtask

    task automatic check_config(input string tag);
        int l, e;
        measure();
        if (meas_ok) begin
            l = (m_per + 1) * (m_pre + 1);
            check({tag, "_len"}, m_len, l);
            for (int c = 0; c < CH; c++) begin
                if (m_duty[c] == 0) e = 0;
                else if (m_duty[c] > m_per) e = l;
                else e = m_duty[c] * (m_pre + 1);
                if (m_inv) e = l - e;
                check($sformatf("%s_hi%0d", tag, c), hi[c], e);
            end
        end
    endtask

    task automatic check_idle(input string tag);
        int err = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (pwm != {CH{m_inv}}) err++;
            if (period) err++;
        end
        check(tag, err, 0);
    endtask

    initial begin
        int v, n, h;
        bus.b_addr_i  = 8'h00;
        bus.b_data_i  = 8'h00;
        bus.b_write_i = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_pwm", int'(pwm), 0);
        check("rst_period", int'(period), 0);
        read_check("rst_rd_ctrl", 0);
        read_check("rst_rd_status", 3);

        // CDC: visible exactly 3 edges after rise, one write per strobe
        @(negedge clk);
        strobe_on(8'h02, 8'h09);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            rd(2, v);
            check($sformatf("cdc_lat_k%0d", k), v, (k >= 3) ? 9 : 0);
            if (k == 3) bus.b_data_i = 8'h0A;
        end
        bus.b_write_i = 1'b0;
        repeat (4) @(negedge clk);
        model_write(2, 9);
        read_check("cdc_single", 2);

        // Directed timing plus duty boundaries
        bus_write(1, 1);
        bus_write(16, 3);
        bus_write(17, 0);
        bus_write(18, 8'hFF);
        bus_write(19, 5);
        bus_write(0, 1);
        check_config("dir");
        bus_write(0, 3);
        check_config("dir_inv");
        read_check("rd_ctrl", 0);
        read_check("rd_unlisted", 8'h05);
        read_check("rd_past_ch", 16 + CH);
        rd(3, v);
        check("status_set", v, 1);
        bus_write(0, 2);
        check_idle("en0_inv_idle");
        bus_write(3, 0);
        rd(3, v);
        check("status_clr", v, 0);

        // Shrink PERIOD below the running count
        bus_write(1, 0);
        bus_write(2, 8'h20);
        bus_write(0, 1);
        measure();
        repeat (12) @(negedge clk);
        strobe_on(8'h02, 8'h05);
        n = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            n++;
            if (period) break;
        end
        bus.b_write_i = 1'b0;
        model_write(2, 5);
`ifdef PWM_SHADOW_EN
        check("shrink_wait", int'(n > 6 && n < 40), 1);
`else
        check("shrink_wait", int'(n <= 6), 1);
`endif
        check_config("shrink");

        // DUTY change mid-period
        bus_write(0, 0);
        bus_write(2, 15);
        bus_write(16, 3);
        bus_write(0, 1);
        measure();
        strobe_on(8'h10, 8'h07);
        h = 0;
        for (int i = 0; i < 100; i++) begin
            h += int'(pwm[0]);
            @(negedge clk);
            if (period) break;
        end
        bus.b_write_i = 1'b0;
        model_write(16, 7);
`ifdef PWM_SHADOW_EN
        check("duty_mid", h, 3);
`else
        check("duty_mid", int'(h > 3 && h <= 7), 1);
`endif
        check_config("duty_after");

        // Randomized configurations
        for (int it = 0; it < 8; it++) begin
            int inv, p;
            inv = int'($urandom_range(0, 1));
            p   = int'($urandom_range(0, 15));
            bus_write(0, inv << 1);
            check_idle($sformatf("rnd%0d_idle", it));
            bus_write(1, int'($urandom_range(0, 3)));
            bus_write(2, p);
            for (int c = 0; c < CH; c++) begin
                int r = int'($urandom_range(0, 3));
                bus_write(16 + c, (r == 0) ? 0 : (r == 1) ? 255 : int'($urandom_range(0, p + 2)));
            end
            bus_write(0, (inv << 1) | 1);
            for (int a = 0; a < 3; a++) read_check($sformatf("rnd%0d_rd%0d", it, a), a);
            for (int c = 0; c < CH; c++) read_check($sformatf("rnd%0d_rdd%0d", it, c), 16 + c);
            check_config($sformatf("rnd%0d", it));
        end

        // Reset in the middle of activity
        bus_write(0, 3);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_pwm", int'(pwm), 0);
        check("rst_mid_period", int'(period), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        read_check("rst_mid_rd0", 0);
        read_check("rst_mid_rd2", 2);
        read_check("rst_mid_rd10", 16);
        check_idle("rst_mid_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
